// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexed scan controller for a common-anode multi-digit
//            seven-segment display. Accepts a packed hex value through a
//            valid/ready handshake, holds it in a pending register, and
//            commits it to the display register only at a frame boundary
//            (or immediately while the scan is disabled), so a frame never
//            mixes old and new digits.
// Ports    : clk, rst_n          - clock, async active-low reset
//            enable              - scan enable (low = dark, scan frozen)
//            blank_lz            - leading-zero suppression enable
//            load_valid/ready    - handshake for value_in
//            value_in            - packed nibbles, [3:0] = rightmost digit
//            digit_data          - nibble for the current slot (to decoder)
//            digit_sel           - active-low one-hot anode enables
//            digit_blank         - current slot suppressed by LZ blanking
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [3:0]              digit_data,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]      presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_full;

  logic                    tick;
  logic                    commit;
  logic                    accept;
  logic                    in_guard;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              nib [NUM_DIGITS];

  assign tick       = enable && (presc == PRESC_LAST);
  // While frozen there is no frame in progress, so a pending value may go
  // straight to the display; otherwise wait for the last slot's tick.
  assign commit     = pend_full && (!enable || (tick && (idx == IDX_LAST)));
  assign accept     = load_valid && !pend_full;
  assign load_ready = !pend_full;

  // Dead time at the start of each slot; a zero-length guard needs no compare.
  if (GUARD_CYCLES == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (presc < PRESC_W'(GUARD_CYCLES));
  end

  // Digit i is blank when every nibble from i upward is zero; digit 0 never
  // blanks so a zero value still shows a single "0".
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign nib[i] = disp_reg[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign blank_vec[i] = 1'b0;
    end else begin : g_upper
      assign blank_vec[i] = blank_lz && (disp_reg[4*NUM_DIGITS-1:4*i] == '0);
    end
  end

  // Prescaler and digit index; both hold while the scan is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (enable) begin
      if (tick) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Pending / display registers. commit requires pend_full and accept
  // requires !pend_full, so the two never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_reg  <= '0;
      disp_reg  <= '0;
    end else if (commit) begin
      disp_reg  <= pend_reg;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_reg  <= value_in;
      pend_full <= 1'b1;
    end
  end

  // Registered outputs, one cycle behind presc/idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_data  <= 4'h0;
      digit_sel   <= '1;
      digit_blank <= 1'b0;
    end else begin
      digit_data  <= nib[idx];
      digit_blank <= blank_vec[idx];
      if (!enable || in_guard || blank_vec[idx]) begin
        digit_sel <= '1;
      end else begin
        digit_sel <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Randomized self-checking bench for seven_seg_scanner
//            (NUM_DIGITS=4, REFRESH_DIV=6, GUARD_CYCLES=2). The reference
//            model tracks a single frame position counter and derives the
//            slot and in-slot phase from it arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 6;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic        load_ready;
  logic [3:0]  digit_data;
  logic [3:0]  digit_sel;
  logic        digit_blank;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .value_in   (value_in),
    .digit_data (digit_data),
    .digit_sel  (digit_sel),
    .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_pos;    // position within the frame, 0 .. ND*RD-1
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;

  // Per-cycle expectations
  int          slot, phase;
  logic [3:0]  e_data, e_sel;
  logic        e_blank;
  bit          tick, commit, accept;
  bit          did_rst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_data",  32'(digit_data),  32'h0);
    check("rst_sel",   32'(digit_sel),   32'hF);
    check("rst_blank", 32'(digit_blank), 32'h0);
    check("rst_ready", 32'(load_ready),  32'h1);
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_full = 1'b0;
  endtask

  // Values with a random count of significant digits, to exercise blanking.
  function automatic logic [15:0] rand_val();
    int k;
    logic [31:0] mask;
    k    = $urandom_range(0, 4);
    mask = (32'h1 << (4*k)) - 1;
    return 16'($urandom & mask);
  endfunction

  initial begin
    did_rst = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      // Drive inputs away from the clock edge
      if (cyc > 100 && $urandom_range(0, 39) == 0) enable = ~enable;
      if (cyc > 50 && $urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      load_valid = ($urandom_range(0, 7) == 0);
      value_in   = rand_val();

      check("load_ready", 32'(load_ready), 32'(!m_full));

      // Expected registered outputs from pre-edge model state
      slot    = m_pos / RD;
      phase   = m_pos % RD;
      e_data  = 4'((m_disp >> (4*slot)) & 16'hF);
      e_blank = blank_lz && (slot != 0) && ((m_disp >> (4*slot)) == 16'h0);
      e_sel   = (!enable || phase < G || e_blank) ? 4'hF : 4'(~(32'h1 << slot));

      // Advance the model across the edge
      tick   = enable && (phase == RD - 1);
      commit = m_full && (!enable || (tick && slot == ND - 1));
      accept = load_valid && !m_full;
      if (commit) begin
        m_disp = m_pend;
        m_full = 1'b0;
      end
      if (accept) begin
        m_pend = value_in;
        m_full = 1'b1;
      end
      if (enable) m_pos = (m_pos + 1) % (ND*RD);

      @(posedge clk);
      #1;
      check("digit_data",  32'(digit_data),  32'(e_data));
      check("digit_sel",   32'(digit_sel),   32'(e_sel));
      check("digit_blank", 32'(digit_blank), 32'(e_blank));

      // Asynchronous reset mid-scan with a pending value in the last slot
      if (!did_rst && cyc > 2000 &&
          ((m_full && enable && (m_pos / RD) == ND - 1) || cyc > 3500)) begin
        did_rst = 1'b1;
        rst_n   = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
